// File: rtl/program_loader.sv
// program_loader
//   Write-side loader for the program memory. Accepts a byte stream over a
//   valid/ready handshake, assembles bytes MSB-first into m-bit words and
//   writes them to consecutive addresses starting at 0, then pulses done.
//
//   Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN): after the last word
//   one more byte is accepted and compared with the XOR of all data bytes;
//   a difference sets error.
//
// Ports:
//   clk         system clock, rising edge
//   clr_n       synchronous active-low reset
//   start       one-cycle load request, only honoured when idle
//   word_count  number of words to load (legal 1..2**n), sampled with start
//   in_data     incoming byte
//   in_valid    in_data is valid
//   in_ready    loader accepts a byte this cycle
//   mem_we      program memory write strobe, one cycle per word
//   mem_addr    program memory write address
//   mem_data    program memory write data
//   busy        high whenever the loader is not idle
//   done        one-cycle pulse at the end of a load
//   error       sticky error flag, cleared by reset or the next start
module program_loader #(
   parameter int unsigned n = 4,
   parameter int unsigned m = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         start,
   input  logic [n:0]   word_count,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [m-1:0] mem_data,
   output logic         busy,
   output logic         done,
   output logic         error
);

   localparam int unsigned B    = m / 8;
   localparam int unsigned CntW = $clog2(B + 1);
   // Largest legal word_count, 2**n.
   localparam logic [n:0]  MaxCount = {1'b1, {n{1'b0}}};

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRecv  = 3'd1,
      StWrite = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck = 3'd3,
`endif
      StDone  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [n:0]        count_q, count_d;
   logic [n-1:0]      addr_q, addr_d;
   logic [m-1:0]      data_q, data_d;
   logic [m-1:0]      shift_q, shift_d;
   logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
   logic              error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic [m-1:0]      shifted;
   logic              last_word;

   // Shift the new byte in at the LSB end; the oldest byte falls off the top.
   assign shifted   = m'({shift_q, in_data});
   assign last_word = ({1'b0, addr_q} + (n+1)'(1)) == count_q;

   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign error    = error_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      addr_d     = addr_q;
      data_d     = data_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      error_d    = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      in_ready   = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               if (word_count != '0 && word_count <= MaxCount) begin
                  count_d    = word_count;
                  error_d    = 1'b0;
                  addr_d     = '0;
                  byte_cnt_d = '0;
                  shift_d    = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum_d     = '0;
`endif
                  state_d    = StRecv;
               end else begin
                  error_d = 1'b1;
                  state_d = StDone;
               end
            end
         end

         StRecv: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift_d = shifted;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ in_data;
`endif
               if (byte_cnt_q == CntW'(B - 1)) begin
                  data_d     = shifted;
                  byte_cnt_d = CntW'(B);
                  state_d    = StWrite;
               end else begin
                  byte_cnt_d = byte_cnt_q + CntW'(1);
               end
            end
         end

         StWrite: begin
            mem_we = 1'b1;
            if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = StCheck;
`else
               state_d = StDone;
`endif
            end else begin
               addr_d     = addr_q + n'(1);
               byte_cnt_d = '0;
               state_d    = StRecv;
            end
         end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StCheck: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data != csum_q) begin
                  error_d = 1'b1;
               end
               state_d = StDone;
            end
         end
`endif

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q    <= StIdle;
         count_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         error_q    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         error_q    <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader (n=4, m=16). A queue of expected
//   (addr, data) writes is built from the byte stream; a monitor on the
//   falling edge compares every write, done pulse and handshake against it.
module tb_program_loader;

   localparam int N = 4;
   localparam int M = 16;

   logic         clk = 1'b0;
   logic         clr_n;
   logic         start;
   logic [N:0]   word_count;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         mem_we;
   logic [N-1:0] mem_addr;
   logic [M-1:0] mem_data;
   logic         busy;
   logic         done;
   logic         error;

   always #5 clk = ~clk;

   program_loader #(
      .n(N),
      .m(M)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .word_count(word_count),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   typedef struct {
      logic [N-1:0] addr;
      logic [M-1:0] data;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   wr_t         exp_q[$];
   logic [7:0]  stim[$];
   logic [M-1:0] tb_mem [16];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   logic        exp_error = 1'b0;
   logic        prev_done = 1'b0;
   int          base_wr;
   int          base_done;
   int          exp_writes;
   logic        cur_bad;
   logic [7:0]  xsum;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (prev_done) check("busy_falls_after_done", busy, 1'b0);
      if (mem_we) begin
         check("ready_low_in_write", in_ready, 1'b0);
         check("busy_in_write", busy, 1'b1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     mem_addr, mem_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", mem_addr, e.addr);
            check("write_data", mem_data, e.data);
         end
         tb_mem[mem_addr] = mem_data;
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         check("error_at_done", error, exp_error);
         check("busy_at_done", busy, 1'b1);
      end
      prev_done = done;
   end

   task automatic send_byte(input logic [7:0] b, input int gaps);
      logic acc;
      int   t;
      repeat (gaps) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         t++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: byte %0h not accepted, required acceptance", b);
      end
      in_valid = 1'b0;
   endtask

   task automatic begin_load(input logic [N:0] cnt, input logic bad);
      logic legal;
      base_wr   = wr_cnt;
      base_done = done_cnt;
      cur_bad   = bad;
      legal     = (cnt != 0) && (cnt <= 16);
      xsum      = 8'h00;
      if (legal) begin
         for (int i = 0; i < int'(cnt); i++) begin
            exp_q.push_back('{addr: N'(i), data: {stim[2*i], stim[2*i+1]}});
            xsum = xsum ^ stim[2*i] ^ stim[2*i+1];
         end
      end
      exp_writes = legal ? int'(cnt) : 0;
      exp_error  = !legal;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (legal && bad) exp_error = 1'b1;
`endif
      start      = 1'b1;
      word_count = cnt;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input int gap_mode);
      for (int i = lo; i < hi; i++) begin
         send_byte(stim[i], (gap_mode != 0) ? (i % 3) : 0);
      end
   endtask

   task automatic finish_load();
      int t;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (exp_writes != 0) send_byte(cur_bad ? (xsum ^ 8'h01) : xsum, 0);
`else
      if (cur_bad) $display("note: checksum not built, bad-checksum flag has no effect");
`endif
      t = 0;
      while (done_cnt == base_done && t < 2000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", done_cnt - base_done, 1);
      check("write_count", wr_cnt - base_wr, exp_writes);
      check("pending_writes", exp_q.size(), 0);
      check("error_sticky", error, exp_error);
      check("busy_idle", busy, 1'b0);
   endtask

   task automatic load(input logic [N:0] cnt, input int gap_mode, input logic bad);
      begin_load(cnt, bad);
      if (exp_writes != 0) send_range(0, 2 * exp_writes, gap_mode);
      finish_load();
   endtask

   task automatic set_stim(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
      stim.delete();
      stim.push_back(b0); stim.push_back(b1); stim.push_back(b2);
      stim.push_back(b3); stim.push_back(b4); stim.push_back(b5);
   endtask

   initial begin
      clr_n      = 1'b0;
      start      = 1'b0;
      word_count = '0;
      in_data    = 8'h00;
      in_valid   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      @(posedge clk); #1;
      clr_n = 1'b1;
      @(posedge clk); #1;

      // Basic load, in_valid always high.
      set_stim(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
      load(5'd3, 0, 1'b0);
      check("basic_mem0", tb_mem[0], 16'h1234);
      check("basic_mem1", tb_mem[1], 16'h5678);
      check("basic_mem2", tb_mem[2], 16'h9ABC);
      check("basic_error", error, 1'b0);

      // Same stream with gaps on in_valid.
      for (int i = 0; i < 3; i++) tb_mem[i] = '0;
      load(5'd3, 1, 1'b0);
      check("gap_mem0", tb_mem[0], 16'h1234);
      check("gap_mem2", tb_mem[2], 16'h9ABC);

      // Full depth.
      stim.delete();
      for (int i = 0; i < 32; i++) stim.push_back(8'(i * 7 + 3));
      load(5'd16, 1, 1'b0);
      check("full_mem0", tb_mem[0], 16'h030A);
      check("full_mem15", tb_mem[15], 16'hD5DC);
      check("full_addr_holds", mem_addr, 4'hF);

      // Illegal counts.
      load(5'd0, 0, 1'b0);
      check("cnt0_error", error, 1'b1);
      load(5'd17, 0, 1'b0);
      check("cnt17_error", error, 1'b1);

      // start while receiving is ignored; a legal start also clears error.
      set_stim(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00);
      begin_load(5'd2, 1'b0);
      send_range(0, 1, 0);
      start      = 1'b1;
      word_count = 5'd5;
      @(posedge clk); #1;
      start      = 1'b0;
      send_range(1, 4, 0);
      finish_load();
      check("restart_mem1", tb_mem[1], 16'h3344);
      check("restart_error_cleared", error, 1'b0);

      // Reset in the middle of RECV.
      set_stim(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
      tb_mem[0] = '0;
      begin_load(5'd3, 1'b0);
      send_range(0, 3, 0);
      clr_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b0);
      check("midrst_mem_we", mem_we, 1'b0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_mem_data", mem_data, 0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      @(posedge clk); #1;
      exp_q.delete();
      base_wr = wr_cnt;
      clr_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("midrst_no_writes", wr_cnt - base_wr, 0);
      check("midrst_idle", busy, 1'b0);
      check("midrst_word_kept", tb_mem[0], 16'h1234);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      set_stim(8'hA5, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00);
      tb_mem[0] = '0;
      load(5'd1, 0, 1'b0);
      check("csum_good_error", error, 1'b0);
      check("csum_good_mem0", tb_mem[0], 16'hA50F);
      tb_mem[0] = '0;
      load(5'd1, 0, 1'b1);
      check("csum_bad_error", error, 1'b1);
      check("csum_bad_mem0", tb_mem[0], 16'hA50F);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the program memory.
- Accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into m-bit instruction words.
- Writes each completed word into sequential program memory addresses from 0, then signals completion.
- Sits between the host/boot byte source and the program memory write port; the memory's read side stays untouched.

Parameters:
- n, 4, address width; memory depth L = 2**n words.
- m, 16, word width; must be a multiple of 8; bytes per word B = m/8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clr_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  input  n+1  number of words to load, sampled with start; legal range 1..L.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  program memory write strobe, one cycle per word.
- mem_addr  output  n  write address.
- mem_data  output  m  write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of load.
- error  output  1  sticky; cleared by the next accepted start or by reset.

Behaviour:
- Reset (clr_n=0 at a clock edge):
  - Goes to IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0.
  - Byte counter and shift register are zeroed.
  - Reset mid-load abandons the load; words already written stay in memory.
- States: IDLE, RECV, WRITE, [CHECK], DONE.
- IDLE:
  - start=1 with word_count in 1..L: latch count, clear error, mem_addr=0, byte_cnt=0, go to RECV.
  - start=1 with word_count=0 or >L: set error, go to DONE; no writes.
- RECV:
  - in_ready=1.
  - A byte is accepted only when in_valid and in_ready are both high in the same cycle.
  - On acceptance: shift_reg <= {shift_reg[m-9:0], in_data}, byte_cnt+1.
  - When the B-th byte is accepted: load mem_data with the completed word and go to WRITE.
  - in_valid low: hold state; no timeout.
- WRITE:
  - mem_we=1 for exactly one cycle with the current mem_addr and mem_data; in_ready=0.
  - If mem_addr == count-1: go to CHECK if the feature is enabled, else DONE.
  - Otherwise: mem_addr+1, byte_cnt=0, return to RECV.
  - mem_addr never wraps, because count ≤ L is guaranteed.
- DONE:
  - done=1 for one cycle, then IDLE.
  - mem_addr and mem_data hold their last values; mem_we=0.
- start while busy: ignored.
- Latency per word: B accept cycles + 1 write cycle.
- Minimum full load: count*(B+1) + 2 cycles from start to the done pulse.
- mem_we is never asserted outside WRITE.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of every accepted data byte is kept.
  - After the last WRITE, enter CHECK with in_ready=1 and accept one more byte.
  - If that byte differs from the running XOR, set error.
  - Then go to DONE.
  - The checksum register resets to 0 on start and on reset.
- Disabled:
  - No CHECK state and no extra byte.
  - error is set only by an illegal word_count.

Test Plan:
- Reset: hold clr_n=0 for 2 cycles mid-RECV -> all outputs 0, state IDLE, no mem_we after release.
- Basic load (n=4, m=16): start, word_count=3, bytes 12 34 56 78 9A BC with in_valid always high ->
  - mem_we pulses at addr 0/1/2 with data 1234/5678/9ABC;
  - done pulses once;
  - busy falls one cycle after done;
  - error=0.
- Backpressure/gaps: same stream with in_valid toggling 1,0,0,1 per byte -> identical writes; no byte lost or duplicated; in_ready=0 during every mem_we cycle.
- Boundaries:
  - word_count=16 -> writes addr 0..15, addr never wraps, done asserted.
  - word_count=0 or 17 -> error=1, done pulses, zero mem_we.
- start re-asserted during RECV -> ignored; load completes with original count.
- Checksum, with PROGRAM_LOADER_CHECKSUM_EN:
  - word_count=1, bytes A5 0F, then checksum AA -> error=0.
  - Same bytes with checksum AB -> error=1 after done.
  - In both cases exactly one write to addr 0 with data A50F.
